g_regfile_sb: RTL

- Parametrised successor to the single-reservation general register file.
- Provides 2 combinational read ports, 1 writeback port and a per-register scoreboard.
- The scoreboard uses a saturating pending-write counter per register, so several in-flight writes to one register are tracked.
- ID reads operands and reserves destinations. WB writes results and releases reservations. EX/branch logic can flush all reservations.

---
 rtl/g_regfile_sb_if.sv | 36 +++
 rtl/g_regfile_sb.sv | 111 +++++++++++
 2 files changed

// File: rtl/g_regfile_sb_if.sv
// Register-file bus for g_regfile_sb: two read ports, reserve port, writeback port, flush, error.
// The master drives register numbers, reserve, writeback and flush; the slave returns data and status.
interface g_regfile_sb_if #(
  parameter int unsigned WORD = 32,
  parameter int unsigned W_RD = 5
) ();

  logic [W_RD-1:0] r0_num_i;
  logic [W_RD-1:0] r1_num_i;
  logic [WORD-1:0] r0_data_o;
  logic [WORD-1:0] r1_data_o;
  logic            r0_busy_o;
  logic            r1_busy_o;

  logic            reserve_i;
  logic [W_RD-1:0] reserve_num_i;
  logic            reserve_full_o;

  logic            wb_i;
  logic [W_RD-1:0] wbr_num_i;
  logic [WORD-1:0] wb_data_i;

  logic            flush_i;
  logic            err_o;

  modport master (
    output r0_num_i, r1_num_i, reserve_i, reserve_num_i, wb_i, wbr_num_i, wb_data_i, flush_i,
    input  r0_data_o, r1_data_o, r0_busy_o, r1_busy_o, reserve_full_o, err_o
  );

  modport slave (
    input  r0_num_i, r1_num_i, reserve_i, reserve_num_i, wb_i, wbr_num_i, wb_data_i, flush_i,
    output r0_data_o, r1_data_o, r0_busy_o, r1_busy_o, reserve_full_o, err_o
  );

endinterface

// File: rtl/g_regfile_sb.sv
// General register file with per-register saturating pending-write scoreboard.
// Optional VENUS_RF_BYPASS_EN: read ports see a same-cycle writeback (data and released busy).
module g_regfile_sb #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned W_RD     = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic           clk,
  input logic           rst,
  g_regfile_sb_if.slave bus
);

  localparam int unsigned NREG = 2 ** W_RD;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CntMax = '1;
  localparam cnt_t CntOne = cnt_t'(1);

  logic [WORD-1:0] data_q [NREG];
  cnt_t            cnt_q  [NREG];
  cnt_t            cnt_d  [NREG];
  logic            err_q, err_d;

  logic            res_full, res_en, wb_en;
  logic [NREG-1:0] inc_vec, hit_vec;

  function automatic logic is_zero(logic [W_RD-1:0] num);
    return (ZERO_REG != 0) && (num == '0);
  endfunction

  // Saturation is judged on the pre-edge counter, regardless of a same-cycle writeback.
  assign res_full = (cnt_q[bus.reserve_num_i] == CntMax);
  assign res_en   = bus.reserve_i & ~res_full & ~is_zero(bus.reserve_num_i) & ~bus.flush_i;
  assign wb_en    = bus.wb_i & ~is_zero(bus.wbr_num_i);

  always_comb begin
    inc_vec = '0;
    hit_vec = '0;
    if (res_en) inc_vec[bus.reserve_num_i] = 1'b1;
    if (wb_en)  hit_vec[bus.wbr_num_i]     = 1'b1;
  end

  // Reserve and writeback on the same register cancel out; flush overrides both.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.flush_i) begin
        cnt_d[i] = '0;
      end else if (inc_vec[i] && !hit_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (hit_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (wb_en && (cnt_q[bus.wbr_num_i] == '0) && !bus.flush_i) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (wb_en) data_q[bus.wbr_num_i] <= bus.wb_data_i;
    end
  end

  always_comb begin
    bus.r0_data_o = data_q[bus.r0_num_i];
    bus.r0_busy_o = (cnt_q[bus.r0_num_i] != '0);
`ifdef VENUS_RF_BYPASS_EN
    if (wb_en && (bus.r0_num_i == bus.wbr_num_i)) begin
      bus.r0_data_o = bus.wb_data_i;
      bus.r0_busy_o = (cnt_q[bus.r0_num_i] > CntOne);
    end
`endif
    if (is_zero(bus.r0_num_i)) begin
      bus.r0_data_o = '0;
      bus.r0_busy_o = 1'b0;
    end
  end

  always_comb begin
    bus.r1_data_o = data_q[bus.r1_num_i];
    bus.r1_busy_o = (cnt_q[bus.r1_num_i] != '0);
`ifdef VENUS_RF_BYPASS_EN
    if (wb_en && (bus.r1_num_i == bus.wbr_num_i)) begin
      bus.r1_data_o = bus.wb_data_i;
      bus.r1_busy_o = (cnt_q[bus.r1_num_i] > CntOne);
    end
`endif
    if (is_zero(bus.r1_num_i)) begin
      bus.r1_data_o = '0;
      bus.r1_busy_o = 1'b0;
    end
  end

  assign bus.reserve_full_o = res_full;
  assign bus.err_o          = err_q;

endmodule
